lfsr_keystream_ctrl: RTL

LFSR_KEYSTREAM_CTRL -- requirements
Module: lfsr_keystream_ctrl

---
 rtl/crypto_pkg.sv | 18 +
 rtl/lfsr_core.sv | 39 +++
 rtl/lfsr_keystream_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/crypto_pkg.sv
// Shared definitions for the keystream generator: controller state encoding,
// default sizing and the LFSR feedback tap mask.
package crypto_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_WARMUP = 32;

    // Feedback taps at bit positions 15, 13, 12 and 10 of the 16-bit register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR: parallel load of a seed, or a single left shift with the
// XOR of the tapped bits entering at bit 0. Load wins over shift.
module lfsr_core
    import crypto_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (shift) begin
            q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lfsr_keystream_ctrl.sv
// Keystream controller: seeds the LFSR, discards WARMUP shifts, then streams
// bits over a valid/ready handshake until the requested count is delivered.
module lfsr_keystream_ctrl
    import crypto_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int WARMUP = DEFAULT_WARMUP
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [7:0]       nbits,
    input  logic             stop,
    input  logic             ks_ready,
    output logic             ks_valid,
    output logic             ks_bit,
    output logic             busy,
    output logic             done,
    output logic             seed_err
);

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_e           state_q;
    logic [7:0]       warm_q;
    logic [8:0]       remain_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             seed_err_q;
    logic             seed_zero;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] lfsr;
    logic             unused_lfsr_low;

    assign seed_zero = (seed == '0);
    assign load      = (state_q == ST_IDLE) && start && !seed_zero;
    // ks_valid is always high in RUN, so ks_ready alone marks a handshake.
    assign shift     = !stop && ((state_q == ST_WARMUP) ||
                                 ((state_q == ST_RUN) && ks_ready));

    lfsr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .clear_n (clear_n),
        .load    (load),
        .shift   (shift),
        .seed    (seed),
        .q       (lfsr)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            warm_q     <= '0;
            remain_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            seed_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (seed_zero) begin
                            seed_err_q <= 1'b1;
                        end else begin
                            state_q  <= ST_WARMUP;
                            warm_q   <= '0;
                            remain_q <= (nbits == 8'd0) ? 9'd256 : {1'b0, nbits};
                            busy_q   <= 1'b1;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (warm_q == WARM_LAST) begin
                        state_q <= ST_RUN;
                        valid_q <= 1'b1;
                    end else begin
                        warm_q <= warm_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (ks_ready) begin
                        remain_q <= remain_q - 9'd1;
                        if (remain_q == 9'd1) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign unused_lfsr_low = ^lfsr[WIDTH-2:0];

    assign ks_valid = valid_q;
    assign ks_bit   = lfsr[WIDTH-1];
    assign busy     = busy_q;
    assign done     = done_q;
    assign seed_err = seed_err_q;

endmodule
